// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
//  Module   : csr_unit
//  Brief    : Machine-mode CSR file for the rv32i core. Returns the old CSR
//             value for rd write-back, runs mcycle/minstret, and applies trap
//             entry and mret updates to mstatus/mepc/mcause.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0004,
    parameter logic [31:0] HART_ID   = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_w,
    input  logic        csr_inm,
    input  logic [2:0]  f3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        instr_retire,
    input  logic        trap,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    output logic [31:0] csr_rdata,
    output logic [31:0] trap_vector,
    output logic [31:0] epc,
    output logic        mie_o,
    output logic        illegal
);

    localparam logic [11:0] c_MSTATUS   = 12'h300;
    localparam logic [11:0] c_MISA      = 12'h301;
    localparam logic [11:0] c_MTVEC     = 12'h305;
    localparam logic [11:0] c_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_MEPC      = 12'h341;
    localparam logic [11:0] c_MCAUSE    = 12'h342;
    localparam logic [11:0] c_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_MHARTID   = 12'hF14;

    localparam logic [1:0]  c_OP_RW = 2'b01;
    localparam logic [1:0]  c_OP_RS = 2'b10;

    // Architectural state; low bits of mtvec/mepc are always zero so they are
    // not stored.
    logic        r_mie;
    logic        r_mpie;
    logic [31:2] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:2] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic        w_impl;
    logic        w_ro;
    logic        w_write_op;
    logic        w_wr_en;
    logic [31:0] w_rdata;
    logic [31:0] w_src;
    logic [31:0] w_new;
    logic        w_unused;

    // Address decode and read mux: returns the pre-write value, 0 when unmapped.
    always_comb begin
        w_impl  = 1'b1;
        w_ro    = 1'b0;
        w_rdata = 32'h0000_0000;
        case (csr_addr)
            c_MSTATUS:   w_rdata = {24'h000000, r_mpie, 3'b000, r_mie, 3'b000};
            c_MISA:      begin w_rdata = MISA_VAL; w_ro = 1'b1; end
            c_MTVEC:     w_rdata = {r_mtvec, 2'b00};
            c_MSCRATCH:  w_rdata = r_mscratch;
            c_MEPC:      w_rdata = {r_mepc, 2'b00};
            c_MCAUSE:    w_rdata = r_mcause;
            c_MCYCLE:    w_rdata = r_mcycle[31:0];
            c_MCYCLEH:   w_rdata = r_mcycle[63:32];
            c_MINSTRET:  w_rdata = r_minstret[31:0];
            c_MINSTRETH: w_rdata = r_minstret[63:32];
            c_MHARTID:   begin w_rdata = HART_ID; w_ro = 1'b1; end
            default:     w_impl = 1'b0;
        endcase
    end

    // funct3 low bits of 00 are a no-op, so they never count as a write to a
    // read-only CSR.
    assign w_write_op = (f3[1:0] != 2'b00);
    assign illegal    = csr_w & (~w_impl | (w_ro & w_write_op));
    assign csr_rdata  = w_impl ? w_rdata : 32'h0000_0000;

    // A trap in the same cycle drops the CSR write entirely.
    assign w_wr_en = csr_w & ~illegal & w_write_op & ~trap;
    assign w_src   = csr_inm ? {27'd0, zimm} : rs1_data;

    // Read-modify-write value for RW / RS / RC.
    always_comb begin
        w_new = w_rdata & ~w_src;
        if (f3[1:0] == c_OP_RW) begin
            w_new = w_src;
        end else if (f3[1:0] == c_OP_RS) begin
            w_new = w_rdata | w_src;
        end
    end

    assign trap_vector = {r_mtvec, 2'b00};
    assign epc         = {r_mepc, 2'b00};
    assign mie_o       = r_mie;

    assign w_unused = ^{f3[2], trap_pc[1:0]};

    // mstatus MIE/MPIE: trap entry, then mret, then CSR write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie  <= 1'b0;
            r_mpie <= 1'b0;
        end else if (trap) begin
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
        end else if (mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr_en && (csr_addr == c_MSTATUS)) begin
            r_mie  <= w_new[3];
            r_mpie <= w_new[7];
        end
    end

    // mtvec and mscratch: plain CSR writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtvec    <= MTVEC_RST[31:2];
            r_mscratch <= 32'h0000_0000;
        end else if (w_wr_en) begin
            if (csr_addr == c_MTVEC) begin
                r_mtvec <= w_new[31:2];
            end
            if (csr_addr == c_MSCRATCH) begin
                r_mscratch <= w_new;
            end
        end
    end

    // mepc/mcause: captured on trap entry, otherwise CSR-writable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mepc   <= 30'd0;
            r_mcause <= 32'h0000_0000;
        end else if (trap) begin
            r_mepc   <= trap_pc[31:2];
            r_mcause <= trap_cause;
        end else if (w_wr_en) begin
            if (csr_addr == c_MEPC) begin
                r_mepc <= w_new[31:2];
            end
            if (csr_addr == c_MCAUSE) begin
                r_mcause <= w_new;
            end
        end
    end

    // mcycle: a write to one half replaces the increment for that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle <= 64'd0;
        end else if (w_wr_en && (csr_addr == c_MCYCLE)) begin
            r_mcycle[31:0] <= w_new;
        end else if (w_wr_en && (csr_addr == c_MCYCLEH)) begin
            r_mcycle[63:32] <= w_new;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    // minstret: same write-wins rule, counting retired instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_minstret <= 64'd0;
        end else if (w_wr_en && (csr_addr == c_MINSTRET)) begin
            r_minstret[31:0] <= w_new;
        end else if (w_wr_en && (csr_addr == c_MINSTRETH)) begin
            r_minstret[63:32] <= w_new;
        end else if (instr_retire) begin
            r_minstret <= r_minstret + 64'd1;
        end
    end

endmodule
`default_nettype wire

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR register file for the rv32i core.
- Consumes the control unit's `csr_w`/`csr_inm` strobes together with `funct3` and the instruction's CSR address.
- Returns the old CSR value for rd write-back, runs the mcycle/minstret counters, and handles trap entry and mret state updates.
- Sits beside the register file in the datapath and feeds the trap vector and return address to PC-next selection.

Parameters:
- `MTVEC_RST`, 32'h0000_0004, reset value of mtvec (bits [1:0] forced 0).
- `HART_ID`, 0, value returned by mhartid.
- `MISA_VAL`, 32'h4000_0100, value returned by misa (RV32I).

Ports:
- `clk` input 1: core clock, rising-edge.
- `rst_n` input 1: asynchronous active-low reset.
- `csr_w` input 1: CSR instruction in this cycle (from control unit).
- `csr_inm` input 1: 1 = source is zimm, 0 = source is rs1_data.
- `f3` input 3: instruction funct3; [1:0] 01 = RW, 10 = RS, 11 = RC.
- `csr_addr` input 12: instruction bits [31:20].
- `rs1_data` input 32: register source operand.
- `zimm` input 5: instruction bits [19:15].
- `instr_retire` input 1: an instruction completes this cycle.
- `trap` input 1: take trap this cycle.
- `trap_cause` input 32: mcause value for the trap.
- `trap_pc` input 32: PC of the faulting instruction.
- `mret` input 1: mret executing this cycle.
- `csr_rdata` output 32: old value of the addressed CSR (combinational).
- `trap_vector` output 32: `{mtvec[31:2], 2'b00}`.
- `epc` output 32: current mepc.
- `mie_o` output 1: mstatus.MIE.
- `illegal` output 1: unimplemented address, or a write to a read-only CSR.

Behaviour:
CSR map (all other addresses are illegal when `csr_w` = 1):
- 0x300 mstatus: only MIE [3] and MPIE [7] are stored; all other bits read 0 and ignore writes.
- 0x301 misa: read-only.
- 0x305 mtvec: bits [1:0] always read 0 (direct mode).
- 0x340 mscratch.
- 0x341 mepc: bits [1:0] written as 0.
- 0x342 mcause.
- 0xB00 / 0xB80: mcycle low / high.
- 0xB02 / 0xB82: minstret low / high.
- 0xF14 mhartid: read-only.

Reset (`rst_n` low, asynchronous, any time):
- mstatus = 0, mtvec = `MTVEC_RST`, mscratch = mepc = mcause = 0, mcycle = minstret = 0.
- Outputs follow these values immediately.
- Any in-flight update is lost.

Read path:
- `csr_rdata` is combinational from `csr_addr`; it returns the pre-write value.
- It returns 0 for illegal addresses.

Write path (rising edge, when `csr_w` = 1 and `illegal` = 0):
- src = `csr_inm` ? {27'b0, zimm} : `rs1_data`.
- RW: new = src. RS: new = old | src. RC: new = old & ~src.
- RS/RC with src = 0 rewrites the same value (no side effects exist).
- `f3[1:0]` = 00 is treated as no write; `illegal` is not raised.
- A write to misa or mhartid asserts `illegal` and is suppressed.

Counters:
- mcycle is 64 bits and increments every cycle out of reset.
- minstret is 64 bits and increments on `instr_retire`.
- Both wrap from 2^64-1 to 0.
- A CSR write to either half wins over the increment that cycle: the written half takes the written value and the other half holds.
- There is no increment carry on that cycle.

Trap (rising edge, `trap` = 1):
- mepc <= {trap_pc[31:2], 2'b00}; mcause <= `trap_cause`; MPIE <= MIE; MIE <= 0.
- A CSR write in the same cycle is dropped.
- Counters still run.

mret (`mret` = 1, `trap` = 0):
- MIE <= MPIE; MPIE <= 1.
- If a CSR write to mstatus occurs in the same cycle, mret wins.

Priority: reset > trap > mret > CSR write > counter increment.

Test Plan:
1. Reset: `rst_n` = 0 mid-count with mcycle = 0x1234 -> all CSRs 0, mtvec = 0x4, `trap_vector` = 0x4, `mie_o` = 0, asynchronously.
2. CSRRW 0x340, rs1_data = 0xDEADBEEF -> `csr_rdata` = 0 that cycle; next read of 0x340 = 0xDEADBEEF. CSRRCI 0x340, zimm = 0x0F -> 0xDEADBEE0.
3. CSRRSI 0x300, zimm = 8 -> `mie_o` = 1. Then trap with cause 0x8000000B, trap_pc = 0x100 -> mepc = 0x100, mcause = 0x8000000B, MIE = 0, MPIE = 1. Then mret -> MIE = 1, MPIE = 1.
4. Write mcycle low = 0xFFFFFFFF and high = 0xFFFFFFFF -> one cycle later both halves = 0 (wrap). Write to 0xB00 with value 5 -> reads 5 next cycle, not 6.
5. `csr_w` to 0x7C0 or 0xF14 -> `illegal` = 1, no state change. Read of 0xF14 without `csr_w` -> `HART_ID`.
6. `trap` and a CSRRW to mtvec in the same cycle -> mtvec unchanged, mepc/mcause updated. `instr_retire` held for 3 cycles -> minstret += 3.
